ysyx_25040101_core_seq: RTL and testbench
=========================================

Name: ysyx_25040101_core_seq

Overview:
Multi-cycle sequencer for the RV32 core datapath. Steps each instruction through fetch, execute, optional memory access and writeback. Latches the fetched instruction for the decoder and consumes the decoder's classification outputs. Gates register-file and PC writes, halts on ebreak, traps bus timeouts, and counts retired instructions.

Parameters:
TIMEOUT_CYCLES, 255, max wait cycles in FETCH/MEM before fault (>=1)
RESET_INST, 32'h00000013, value of inst_o after reset (nop)

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high reset
ifu_req_o  out  1  instruction fetch request; held high until accepted
ifu_rvalid_i  in  1  fetch response valid
ifu_inst_i  in  32  fetched instruction
inst_o  out  32  latched instruction to decoder
dec_rd_wen_i  in  1  decoder: instruction writes rd
dec_mem_read_i  in  1  decoder: any load (OR of read enables)
dec_mem_write_i  in  1  decoder: any store (OR of write enables)
dec_ebreak_i  in  1  decoder: ebreak
lsu_req_o  out  1  data access request; held until done
lsu_wen_o  out  1  1 = store, 0 = load; valid while lsu_req_o
lsu_done_i  in  1  data access complete
rd_wen_o  out  1  gated register-file write enable
pc_wen_o  out  1  PC update pulse
halt_o  out  1  sticky halt after ebreak
fault_o  out  1  sticky fault
fault_cause_o  out  2  01 fetch timeout, 10 lsu timeout, 11 decode conflict
minstret_o  out  32  retired-instruction count
state_o  out  3  debug state: IDLE=0 FETCH=1 EXEC=2 MEM=3 WB=4 HALT=5 FAULT=6

Behaviour:
- Reset (reset=1 at a clock edge):
  - state=IDLE, inst_o=RESET_INST, minstret_o=0, fault_cause_o=0, timeout counter=0.
  - All request/enable/status outputs are 0.
  - Reset wins from any state, including mid-fetch, mid-MEM, HALT and FAULT.
- Outputs ifu_req_o, lsu_req_o, lsu_wen_o, rd_wen_o, pc_wen_o, halt_o and fault_o are Moore decodes of state only (lsu_wen_o and rd_wen_o also take the decoder inputs). No request is driven in IDLE.
- IDLE: go to FETCH next cycle. Any ifu_rvalid_i/lsu_done_i seen in IDLE is ignored.
- FETCH: ifu_req_o=1.
  - On ifu_rvalid_i: inst_o<=ifu_inst_i, go to EXEC.
  - Otherwise the counter increments; when it reaches TIMEOUT_CYCLES: cause=01, go to FAULT.
  - ifu_rvalid_i on the same cycle the counter hits the limit is accepted (valid has priority).
- EXEC: decoder outputs are combinational from inst_o and stable. Priority order:
  - dec_mem_read_i and dec_mem_write_i both set: cause=11, go to FAULT.
  - dec_ebreak_i: minstret+1, go to HALT.
  - dec_mem_read_i or dec_mem_write_i set: go to MEM (counter cleared).
  - Otherwise go to WB.
- MEM: lsu_req_o=1, lsu_wen_o=dec_mem_write_i.
  - On lsu_done_i: go to WB.
  - Timeout uses the same rule as FETCH: cause=10, go to FAULT.
- WB: one cycle. rd_wen_o=dec_rd_wen_i, pc_wen_o=1, minstret+1 (wraps 0xFFFFFFFF to 0). Then go to FETCH (counter cleared).
- HALT: halt_o=1. No requests, no writes. Exit only by reset.
- FAULT: fault_o=1, fault_cause_o held. No writes or PC update. Exit only by reset.
- The counter clears on every entry to FETCH or MEM.
- Latency:
  - Non-memory instruction: 3 cycles (FETCH, EXEC, WB) with zero-wait fetch.
  - Load/store: 4 cycles with zero-wait fetch and LSU.
- rd_wen_o and pc_wen_o are each high for exactly one cycle per retired non-ebreak instruction.

Test Plan:
- Reset held 3 cycles, released; ifu_rvalid_i tied high, inst=addi (dec_rd_wen=1) -> state 0,1,2,4,1...; rd_wen_o and pc_wen_o pulse every 3rd cycle; minstret_o=3 after 9 cycles from FETCH entry.
- Load with lsu_done_i delayed 5 cycles -> lsu_req_o high 6 cycles, lsu_wen_o=0; then single WB pulse; minstret_o increments by 1.
- Fetch never valid, TIMEOUT_CYCLES=4 -> FAULT after 4 FETCH cycles; fault_cause_o=01; no pc_wen_o pulse; remains in FAULT until reset.
- Decoder drives mem_read=mem_write=1 in EXEC -> FAULT with cause 11 next cycle; lsu_req_o never asserted.
- ebreak after two addi -> halt_o=1 sticky, minstret_o=3, ifu_req_o=0 forever; reset -> IDLE, halt_o=0, minstret_o=0.
- Reset asserted mid-MEM while lsu_done_i=1 -> next state IDLE, no WB pulse; minstret_o=0, inst_o=0x00000013.

Source files
------------

// File: rtl/ysyx_25040101_core_seq.sv
// Multi-cycle instruction sequencer for the RV32 core datapath.
// Steps each instruction through FETCH -> EXEC -> (MEM) -> WB. It latches the
// fetched word for the decoder and gates the register-file and PC writes.
// It halts on ebreak, traps bus timeouts and counts retired instructions.
module ysyx_25040101_core_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_INST     = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    output logic        ifu_req_o,
    input  logic        ifu_rvalid_i,
    input  logic [31:0] ifu_inst_i,
    output logic [31:0] inst_o,
    input  logic        dec_rd_wen_i,
    input  logic        dec_mem_read_i,
    input  logic        dec_mem_write_i,
    input  logic        dec_ebreak_i,
    output logic        lsu_req_o,
    output logic        lsu_wen_o,
    input  logic        lsu_done_i,
    output logic        rd_wen_o,
    output logic        pc_wen_o,
    output logic        halt_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    output logic [31:0] minstret_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    localparam logic [1:0] CAUSE_FETCH  = 2'b01;
    localparam logic [1:0] CAUSE_LSU    = 2'b10;
    localparam logic [1:0] CAUSE_DECODE = 2'b11;

    state_t      r_state;
    logic [31:0] r_inst;
    logic [31:0] r_minstret;
    logic [1:0]  r_cause;
    logic [31:0] r_cnt;

    logic [31:0] w_cnt_inc;
    logic        w_timeout;
    logic        w_mem_op;

    assign w_cnt_inc = r_cnt + 32'd1;
    // The wait cycle that brings the count up to the limit is the last one allowed.
    assign w_timeout = (w_cnt_inc == TIMEOUT_LIM);
    assign w_mem_op  = dec_mem_read_i | dec_mem_write_i;

    // Sequencer state, latched instruction, retire counter and fault cause.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_inst     <= RESET_INST;
            r_minstret <= '0;
            r_cause    <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_cnt   <= '0;
                end
                S_FETCH: begin
                    // A response in the limit cycle still wins over the timeout.
                    if (ifu_rvalid_i) begin
                        r_inst  <= ifu_inst_i;
                        r_state <= S_EXEC;
                    end else if (w_timeout) begin
                        r_cause <= CAUSE_FETCH;
                        r_state <= S_FAULT;
                        r_cnt   <= w_cnt_inc;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                S_EXEC: begin
                    if (dec_mem_read_i && dec_mem_write_i) begin
                        r_cause <= CAUSE_DECODE;
                        r_state <= S_FAULT;
                    end else if (dec_ebreak_i) begin
                        r_minstret <= r_minstret + 32'd1;
                        r_state    <= S_HALT;
                    end else if (w_mem_op) begin
                        r_cnt   <= '0;
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (lsu_done_i) begin
                        r_state <= S_WB;
                    end else if (w_timeout) begin
                        r_cause <= CAUSE_LSU;
                        r_state <= S_FAULT;
                        r_cnt   <= w_cnt_inc;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                S_WB: begin
                    r_minstret <= r_minstret + 32'd1;
                    r_cnt      <= '0;
                    r_state    <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Moore decodes of the registered state; write enables pick up decoder hints.
    assign ifu_req_o     = (r_state == S_FETCH);
    assign lsu_req_o     = (r_state == S_MEM);
    assign lsu_wen_o     = (r_state == S_MEM) && dec_mem_write_i;
    assign rd_wen_o      = (r_state == S_WB) && dec_rd_wen_i;
    assign pc_wen_o      = (r_state == S_WB);
    assign halt_o        = (r_state == S_HALT);
    assign fault_o       = (r_state == S_FAULT);
    assign fault_cause_o = r_cause;
    assign minstret_o    = r_minstret;
    assign inst_o        = r_inst;
    assign state_o       = r_state;

endmodule

// File: tb/tb_ysyx_25040101_core_seq.sv
// Directed bench for the core sequencer. One instance uses the default timeout.
// A second instance uses a short timeout of 4 for the fetch/LSU timeout corners.
module tb_ysyx_25040101_core_seq;

    localparam logic [31:0] INST_ADDI = 32'h0010_0093;
    localparam logic [31:0] INST_LW   = 32'h0000_a103;
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_rvalid;
    logic [31:0] ifu_inst;
    logic        dec_rd_wen, dec_mem_read, dec_mem_write, dec_ebreak;
    logic        lsu_done;

    logic        ifu_req, lsu_req, lsu_wen, rd_wen, pc_wen, halt, fault;
    logic [1:0]  cause;
    logic [31:0] inst, minstret;
    logic [2:0]  state;

    logic        t_ifu_req, t_lsu_req, t_lsu_wen, t_rd_wen, t_pc_wen, t_halt, t_fault;
    logic [1:0]  t_cause;
    logic [31:0] t_inst, t_minstret;
    logic [2:0]  t_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    ysyx_25040101_core_seq dut (
        .clock(clock), .reset(reset),
        .ifu_req_o(ifu_req), .ifu_rvalid_i(ifu_rvalid), .ifu_inst_i(ifu_inst),
        .inst_o(inst),
        .dec_rd_wen_i(dec_rd_wen), .dec_mem_read_i(dec_mem_read),
        .dec_mem_write_i(dec_mem_write), .dec_ebreak_i(dec_ebreak),
        .lsu_req_o(lsu_req), .lsu_wen_o(lsu_wen), .lsu_done_i(lsu_done),
        .rd_wen_o(rd_wen), .pc_wen_o(pc_wen), .halt_o(halt), .fault_o(fault),
        .fault_cause_o(cause), .minstret_o(minstret), .state_o(state)
    );

    ysyx_25040101_core_seq #(.TIMEOUT_CYCLES(4)) dut_t4 (
        .clock(clock), .reset(reset),
        .ifu_req_o(t_ifu_req), .ifu_rvalid_i(ifu_rvalid), .ifu_inst_i(ifu_inst),
        .inst_o(t_inst),
        .dec_rd_wen_i(dec_rd_wen), .dec_mem_read_i(dec_mem_read),
        .dec_mem_write_i(dec_mem_write), .dec_ebreak_i(dec_ebreak),
        .lsu_req_o(t_lsu_req), .lsu_wen_o(t_lsu_wen), .lsu_done_i(lsu_done),
        .rd_wen_o(t_rd_wen), .pc_wen_o(t_pc_wen), .halt_o(t_halt), .fault_o(t_fault),
        .fault_cause_o(t_cause), .minstret_o(t_minstret), .state_o(t_state)
    );

    typedef struct {
        logic        rst;
        logic        rvalid;
        logic [2:0]  exp_state;
        logic        exp_ifu_req;
        logic        exp_rd_wen;
        logic        exp_pc_wen;
        logic [31:0] exp_minstret;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        ifu_rvalid = 0; ifu_inst = '0; dec_rd_wen = 0; dec_mem_read = 0;
        dec_mem_write = 0; dec_ebreak = 0; lsu_done = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        int n_req;

        reset = 1; ifu_rvalid = 0; ifu_inst = INST_ADDI; dec_rd_wen = 1;
        dec_mem_read = 0; dec_mem_write = 0; dec_ebreak = 0; lsu_done = 0;

        // Addi stream with zero-wait fetch: reset for 3 cycles, then a 3-cycle cadence.
        vecs[0]  = '{1, 0, 3'd0, 0, 0, 0, 32'd0};
        vecs[1]  = '{1, 0, 3'd0, 0, 0, 0, 32'd0};
        vecs[2]  = '{1, 0, 3'd0, 0, 0, 0, 32'd0};
        vecs[3]  = '{0, 1, 3'd1, 1, 0, 0, 32'd0};
        vecs[4]  = '{0, 1, 3'd2, 0, 0, 0, 32'd0};
        vecs[5]  = '{0, 1, 3'd4, 0, 1, 1, 32'd0};
        vecs[6]  = '{0, 1, 3'd1, 1, 0, 0, 32'd1};
        vecs[7]  = '{0, 1, 3'd2, 0, 0, 0, 32'd1};
        vecs[8]  = '{0, 1, 3'd4, 0, 1, 1, 32'd1};
        vecs[9]  = '{0, 1, 3'd1, 1, 0, 0, 32'd2};
        vecs[10] = '{0, 1, 3'd2, 0, 0, 0, 32'd2};
        vecs[11] = '{0, 1, 3'd4, 0, 1, 1, 32'd2};
        vecs[12] = '{0, 1, 3'd1, 1, 0, 0, 32'd3};

        for (int i = 0; i < 13; i++) begin
            reset      = vecs[i].rst;
            ifu_rvalid = vecs[i].rvalid;
            tick();
            check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d ifu_req", i), 32'(ifu_req), 32'(vecs[i].exp_ifu_req));
            check($sformatf("vec%0d rd_wen", i), 32'(rd_wen), 32'(vecs[i].exp_rd_wen));
            check($sformatf("vec%0d pc_wen", i), 32'(pc_wen), 32'(vecs[i].exp_pc_wen));
            check($sformatf("vec%0d minstret", i), minstret, vecs[i].exp_minstret);
            if (i == 2) check("reset inst", inst, INST_NOP);
        end
        check("addi latched", inst, INST_ADDI);

        // Load with the LSU answering in the 6th MEM cycle.
        ifu_inst = INST_LW; dec_mem_read = 1;
        tick();
        check("lw exec", 32'(state), 32'd2);
        check("lw latched", inst, INST_LW);
        tick();
        check("lw mem", 32'(state), 32'd3);
        check("lw wen", 32'(lsu_wen), 32'd0);
        n_req = 0;
        for (int c = 0; c < 20; c++) begin
            if (!lsu_req) break;
            n_req++;
            lsu_done = (n_req == 6);
            tick();
        end
        check("lw req cycles", 32'(n_req), 32'd6);
        check("lw wb state", 32'(state), 32'd4);
        check("lw wb rd_wen", 32'(rd_wen), 32'd1);
        check("lw wb pc_wen", 32'(pc_wen), 32'd1);
        check("lw wb minstret", minstret, 32'd3);
        tick();
        check("lw retire", minstret, 32'd4);
        check("lw single pc pulse", 32'(pc_wen), 32'd0);

        // Zero-wait store: 4 cycles, store flag on the LSU, no rd write.
        dec_mem_read = 0; dec_mem_write = 1; dec_rd_wen = 0; lsu_done = 1;
        tick();
        tick();
        check("sw mem", 32'(state), 32'd3);
        check("sw wen", 32'(lsu_wen), 32'd1);
        tick();
        check("sw wb rd_wen", 32'(rd_wen), 32'd0);
        check("sw wb pc_wen", 32'(pc_wen), 32'd1);
        tick();
        check("sw retire", minstret, 32'd5);
        check("sw refetch", 32'(state), 32'd1);

        // Fetch timeout on the short-timeout instance.
        do_reset();
        tick();
        check("t4 fetch entry", 32'(t_state), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t4 fetch wait", 32'(t_state), 32'd1);
            check("t4 fetch no pc", 32'(t_pc_wen), 32'd0);
        end
        tick();
        check("t4 fetch fault", 32'(t_state), 32'd6);
        check("t4 fetch fault_o", 32'(t_fault), 32'd1);
        check("t4 fetch cause", 32'(t_cause), 32'd1);
        for (int c = 0; c < 4; c++) begin
            ifu_rvalid = 1;
            tick();
            check("t4 fault sticky", 32'(t_state), 32'd6);
            check("t4 fault no pc", 32'(t_pc_wen), 32'd0);
        end

        // Valid arriving in the limit cycle is accepted.
        do_reset();
        tick();
        for (int c = 0; c < 3; c++) tick();
        ifu_rvalid = 1;
        tick();
        check("t4 valid at limit", 32'(t_state), 32'd2);
        check("t4 valid no fault", 32'(t_fault), 32'd0);

        // LSU timeout on the short-timeout instance.
        do_reset();
        ifu_rvalid = 1; dec_mem_read = 1;
        tick();
        tick();
        tick();
        check("t4 mem entry", 32'(t_state), 32'd3);
        for (int c = 0; c < 3; c++) tick();
        check("t4 mem wait", 32'(t_state), 32'd3);
        tick();
        check("t4 lsu fault", 32'(t_state), 32'd6);
        check("t4 lsu cause", 32'(t_cause), 32'd2);
        reset = 1;
        tick();
        reset = 0;
        check("t4 reset from fault", 32'(t_state), 32'd0);
        check("t4 reset cause", 32'(t_cause), 32'd0);

        // Decode conflict: load and store together.
        do_reset();
        ifu_rvalid = 1; dec_mem_read = 1; dec_mem_write = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("conflict no lsu_req", 32'(lsu_req), 32'd0);
        end
        check("conflict fault", 32'(state), 32'd6);
        check("conflict cause", 32'(cause), 32'd3);
        tick();
        check("conflict sticky", 32'(state), 32'd6);
        check("conflict sticky no lsu_req", 32'(lsu_req), 32'd0);

        // ebreak after two addi.
        do_reset();
        ifu_rvalid = 1; dec_rd_wen = 1; ifu_inst = INST_ADDI;
        for (int c = 0; c < 7; c++) tick();
        check("pre-ebreak minstret", minstret, 32'd2);
        dec_ebreak = 1;
        tick();
        tick();
        check("halt state", 32'(state), 32'd5);
        check("halt_o", 32'(halt), 32'd1);
        check("halt minstret", minstret, 32'd3);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("halt no ifu_req", 32'(ifu_req), 32'd0);
            check("halt no writes", 32'({rd_wen, pc_wen, lsu_req}), 32'd0);
            check("halt sticky", 32'(halt), 32'd1);
        end
        reset = 1;
        tick();
        reset = 0;
        check("halt reset state", 32'(state), 32'd0);
        check("halt reset halt_o", 32'(halt), 32'd0);
        check("halt reset minstret", minstret, 32'd0);

        // Reset wins mid-MEM even with lsu_done high.
        do_reset();
        ifu_rvalid = 1; dec_mem_read = 1; dec_rd_wen = 1; ifu_inst = INST_LW;
        tick();
        tick();
        tick();
        check("midmem state", 32'(state), 32'd3);
        reset = 1; lsu_done = 1;
        tick();
        check("midmem reset state", 32'(state), 32'd0);
        check("midmem no pc", 32'(pc_wen), 32'd0);
        check("midmem no rd", 32'(rd_wen), 32'd0);
        check("midmem minstret", minstret, 32'd0);
        check("midmem inst", inst, INST_NOP);
        reset = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
